// File: rtl/memory_seq_tester.sv
// memory_seq_tester: fills a RAM with a selectable pattern and optionally reads it back and checks every word
module memory_seq_tester #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk_fnl,
  input  logic              rst,
  input  logic              on_button,
  input  logic [1:0]        mode,
  input  logic [1:0]        pattern,
  input  logic [WIDTH-1:0]  data_out,
  output logic              write,
  output logic              enable,
  output logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  data_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   err_count
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, address_n, err_addr_n;
  logic [1:0] dcnt, dcnt_n, mode_q, mode_qn, pat_q, pat_qn;
  logic [WIDTH-1:0] data_in_n;
  logic write_n, enable_n, busy_n, done_n, error_n, mism;
  logic [ADDR_W:0] err_count_n;
  logic [READ_LAT-1:0] pv;
  logic [ADDR_W-1:0] pa [READ_LAT];
  function automatic logic [WIDTH-1:0] pat_fn(input logic [1:0] p, input logic [ADDR_W-1:0] a);
    int ai;
    logic [WIDTH-1:0] th;
    ai = int'(a);
    th = (ai + 1 >= WIDTH) ? '1 : WIDTH'((33'(1) << (ai + 1)) - 33'd1);
    return p == 2'd0 ? th : p == 2'd1 ? WIDTH'(a) : p == 2'd2 ? WIDTH'(33'(1) << (ai % WIDTH)) : ~th;
  endfunction
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dcnt_n = dcnt;
    mode_qn = mode_q;
    pat_qn = pat_q;
    write_n = 1'b0;
    enable_n = 1'b0;
    address_n = '0;
    data_in_n = '0;
    busy_n = 1'b0;
    done_n = 1'b0;
    mism = pv[READ_LAT-1] && (data_out != pat_fn(pat_q, pa[READ_LAT-1]));
    error_n = error | mism;
    err_addr_n = (mism && !error) ? pa[READ_LAT-1] : err_addr;
    err_count_n = (mism && err_count != CNT_MAX) ? err_count + 1'b1 : err_count;
    case (state)
      IDLE: if (on_button) begin
        mode_qn = mode;
        pat_qn = pattern;
        error_n = 1'b0;
        err_addr_n = '0;
        err_count_n = '0;
        cnt_n = '0;
        state_n = (mode == 2'b10) ? READ : WRITE;
        write_n = mode != 2'b10;
        enable_n = 1'b1;
        busy_n = 1'b1;
        data_in_n = write_n ? pat_fn(pattern, '0) : '0;
      end
      WRITE: if (&cnt) begin
        state_n = (mode_q == 2'b00) ? DONE : READ;
        cnt_n = '0;
        done_n = mode_q == 2'b00;
        enable_n = mode_q != 2'b00;
        busy_n = mode_q != 2'b00;
      end else begin
        cnt_n = cnt + 1'b1;
        write_n = 1'b1;
        enable_n = 1'b1;
        busy_n = 1'b1;
        address_n = cnt_n;
        data_in_n = pat_fn(pat_q, cnt_n);
      end
      READ: if (&cnt) begin
        state_n = DRAIN;
        dcnt_n = '0;
        busy_n = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
        enable_n = 1'b1;
        busy_n = 1'b1;
        address_n = cnt_n;
      end
      DRAIN: if (dcnt == 2'(READ_LAT - 1)) begin
        state_n = DONE;
        done_n = 1'b1;
      end else begin
        dcnt_n = dcnt + 1'b1;
        busy_n = 1'b1;
      end
      DONE: begin
        done_n = on_button;
        state_n = on_button ? DONE : IDLE;
      end
      default: state_n = IDLE;
    endcase
    // releasing the button mid-run abandons the sequence without raising done
    if (state inside {WRITE, READ, DRAIN} && !on_button) begin
      state_n = IDLE;
      write_n = 1'b0;
      enable_n = 1'b0;
      address_n = '0;
      data_in_n = '0;
      busy_n = 1'b0;
      done_n = 1'b0;
    end
  end
  always_ff @(posedge clk_fnl) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dcnt <= '0;
      mode_q <= '0;
      pat_q <= '0;
      write <= 1'b0;
      enable <= 1'b0;
      address <= '0;
      data_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_addr <= '0;
      err_count <= '0;
      pv <= '0;
      for (int i = 0; i < READ_LAT; i++) pa[i] <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dcnt <= dcnt_n;
      mode_q <= mode_qn;
      pat_q <= pat_qn;
      write <= write_n;
      enable <= enable_n;
      address <= address_n;
      data_in <= data_in_n;
      busy <= busy_n;
      done <= done_n;
      error <= error_n;
      err_addr <= err_addr_n;
      err_count <= err_count_n;
      // the read presented this cycle enters the compare pipeline; an abort flushes it
      pv[0] <= (state_n != IDLE) && enable && !write;
      pa[0] <= address;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= (state_n != IDLE) && pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
endmodule

// File: doc/memory_seq_tester.md
# memory_seq_tester

Parametrised memory write/verify sequencer for the lab memory experiments: while `on_button` is held, it fills a `DEPTH`×`WIDTH` RAM with a selectable pattern, then optionally reads every location back and checks it. It drives the RAM's `write`/`enable`/`address`/`data_in` directly and takes `data_out` back. It is the generalised successor of the fixed 16×16 thermometer writer, adding width/depth parameters, pattern and mode selection, read-back verification, and status flags for LEDs.

## Interface
- `WIDTH`, 16, data word width (1..32)
- `ADDR_W`, 4, address width; `DEPTH` = 2**`ADDR_W` (derived, not overridable)
- `READ_LAT`, 1, RAM read latency in cycles (1..3)

- `clk_fnl`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `on_button`  in  1  run request (level); deassertion aborts
- `mode`  in  2  00 write-only, 01 write+verify, 10 verify-only, 11 = 01
- `pattern`  in  2  00 thermometer, 01 address, 10 walking one, 11 inverted thermometer
- `data_out`  in  WIDTH  RAM read data
- `write`  out  1  RAM write enable
- `enable`  out  1  RAM chip enable
- `address`  out  ADDR_W  RAM address
- `data_in`  out  WIDTH  RAM write data
- `busy`  out  1  sequence in progress
- `done`  out  1  sequence completed, held until `on_button` drops
- `error`  out  1  sticky: at least one read-back mismatch
- `err_addr`  out  ADDR_W  address of first mismatch
- `err_count`  out  ADDR_W+1  mismatch count, saturates at DEPTH

## Operation
- Pattern for address a: thermometer = lowest min(a+1, WIDTH) bits set; address = a zero-extended or truncated to WIDTH; walking one = 1 << (a mod WIDTH); inverted thermometer = bitwise NOT of thermometer.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE. All outputs are registered.
- IDLE: `write`=`enable`=`busy`=`done`=0, `address`=0, `data_in`=0. If `on_button`=1, latch `mode`/`pattern`, clear `error`/`err_addr`/`err_count`, and go to WRITE (mode 10: go to READ).
- WRITE: `enable`=1, `write`=1, `address`=a, `data_in`=pattern(a), with a = 0..DEPTH-1, one location per cycle. After a = DEPTH-1: go to DONE (mode 00), otherwise go to READ with a reset to 0.
- READ: `enable`=1, `write`=0, `data_in`=0, `address`=a = 0..DEPTH-1. The issued address and a valid flag pass through a READ_LAT-deep pipeline. After the last issue, go to DRAIN.
- DRAIN: `enable`=0, held for READ_LAT cycles while outstanding compares finish, then go to DONE.
- Compare: on each valid pipeline output, `data_out` ≠ pattern(piped addr) gives:
  - `error` set;
  - `err_count` incremented (saturating);
  - `err_addr` loaded only if this is the first mismatch.
- DONE: `done`=1, `busy`=0, RAM controls 0, status held. Go to IDLE when `on_button`=0.
- Abort: `on_button`=0 in WRITE/READ/DRAIN → IDLE on the next edge. RAM controls go to 0 and the pipeline is flushed. `done` is not set; status keeps its partial values until the next start.
- Mode/pattern changes during a run are ignored.
- `rst`=1 at any edge, including mid-sequence, forces IDLE. All outputs and status go to 0 on the following cycle, and the pipeline valid bits are cleared.
- Reset values: every output is 0.

## Timing
- Edge 0 samples `on_button`=1 in IDLE.
- Write phase: cycles 1..DEPTH carry writes to addresses 0..DEPTH-1.
- Mode 00: `done`=1 from cycle DEPTH+1.
- Mode 01:
  - Reads occupy cycles DEPTH+1..2·DEPTH.
  - A read issued in cycle c has `data_out` valid in cycle c+READ_LAT, sampled at the end of that cycle.
  - DRAIN occupies cycles 2·DEPTH+1..2·DEPTH+READ_LAT.
  - `done` rises in cycle 2·DEPTH+READ_LAT+1, together with the final `error`/`err_count`.
- Mode 10: as mode 01 shifted earlier by DEPTH cycles.
- `busy` is high exactly during the WRITE/READ/DRAIN cycles.
- Restart requires at least one cycle with `on_button`=0 after DONE.

## Test plan
- Defaults, mode 00, pattern 00, hold `on_button` → 16 writes in cycles 1..16: addr 0 data 0x0001, addr 3 data 0x000F, addr 15 data 0xFFFF. `done` in cycle 17; `error`=0.
- Mode 01, pattern 10, ideal RAM model with READ_LAT=1 → reads in cycles 17..32, `done` in cycle 34, `error`=0, `err_count`=0.
- Mode 01 with the RAM model corrupting addresses 5 and 9 → `error`=1, `err_addr`=5, `err_count`=2 at `done`.
- WIDTH=8, ADDR_W=5, READ_LAT=3, pattern 00, mode 01:
  - addr 7 and above write 0xFF;
  - walking-one pattern wraps so that addr 8 writes 0x01;
  - `done` in cycle 68.
- Drop `on_button` at cycle 7 of WRITE → IDLE next cycle, `write`=`enable`=0, `done` never rises. Reassert → clean restart at addr 0 with status cleared.
- Assert `rst` mid-READ together with `on_button`=1 → every output is 0 the next cycle. After `rst` is released, the sequence restarts from WRITE addr 0.
